// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - register map, scheduler states and write helpers for the PWM update scheduler
package pwm_sched_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int NUM_REGS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGED = 2'd1,
    COMMIT = 2'd2
  } sched_state_e;

  // One complete register set; shadow and committed copies share this layout
  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
  } pwm_regs_t;

  function automatic logic addr_mapped(input logic [6:0] addr);
    return addr < 7'(NUM_REGS);
  endfunction

  // Returns the register set with one byte replaced; unmapped addresses leave it untouched
  function automatic pwm_regs_t apply_write(input pwm_regs_t regs, input logic [6:0] addr,
                                            input logic [7:0] data);
    pwm_regs_t nxt;
    nxt = regs;
    case (addr)
      ADDR_EN_OUT_LO: nxt.en_out[7:0]  = data;
      ADDR_EN_OUT_HI: nxt.en_out[15:8] = data;
      ADDR_EN_PWM_LO: nxt.en_pwm[7:0]  = data;
      ADDR_EN_PWM_HI: nxt.en_pwm[15:8] = data;
      ADDR_DUTY:      nxt.duty         = data;
      default:        ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides the system clock into a one-clock tick every DIV clocks
module pwm_prescaler #(
  parameter int DIV = 3000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] count;

  assign tick = (count == LAST);

  // Count 0..DIV-1 and restart; with DIV=1 the count stays 0 and tick is always high
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// rtl/pwm_update_scheduler.sv - boundary-committed PWM register writes and pin drive; PWM_SHADOW_EN enables shadow staging
module pwm_update_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DIV = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  output logic        pending,
  output logic        period_start,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty,
  output logic [15:0] pwm_o
);

  logic      tick;
  logic      wrap;
  logic      wrap_q;
  logic      wr_fire;
  logic      pwm_bit;
  logic [7:0] cnt;
  logic [15:0] pwm_nxt;
  pwm_regs_t live_q;
  pwm_regs_t pin_src;

  pwm_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap    = tick && (cnt == 8'hFF);
  assign wr_fire = wr_valid && wr_ready;

  // Period counter advances once per prescaler tick and wraps 255 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  // period_start trails wrap by two clocks so it lines up with the first pin value of the new period
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wrap_q       <= wrap;
      period_start <= wrap_q;
    end
  end

  // Flag accepted writes that hit no register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_fire && !addr_mapped(wr_addr);
    end
  end

`ifdef PWM_SHADOW_EN
  sched_state_e state;
  sched_state_e state_nxt;
  pwm_regs_t    shadow_q;
  logic         commit_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage on the first mapped write, commit on the period wrap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_fire && addr_mapped(wr_addr)) state_nxt = STAGED;
      STAGED:  if (wrap) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes are held off while the boundary copy is in flight so none is lost or half-applied
  always_comb begin
    wr_ready  = 1'b1;
    pending   = 1'b0;
    commit_en = 1'b0;
    case (state)
      STAGED: begin
        pending  = 1'b1;
        wr_ready = !wrap;
      end
      COMMIT: begin
        pending   = 1'b1;
        wr_ready  = 1'b0;
        commit_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow copy collects writes; last write to an address wins
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (wr_fire) begin
      shadow_q <= apply_write(shadow_q, wr_addr, wr_data);
    end
  end

  // All five registers move to the committed set together
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
    end else if (commit_en) begin
      live_q <= shadow_q;
    end
  end

  // During COMMIT the pins already use the incoming set, so cnt=0 never shows with stale settings
  assign pin_src = commit_en ? shadow_q : live_q;
`else
  assign wr_ready = 1'b1;
  assign pending  = 1'b0;

  // Writes go straight to the committed set; mid-period glitches are accepted in this build
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
    end else if (wr_fire) begin
      live_q <= apply_write(live_q, wr_addr, wr_data);
    end
  end

  assign pin_src = live_q;
`endif

  assign en_out = live_q.en_out;
  assign en_pwm = live_q.en_pwm;
  assign duty   = live_q.duty;

  // Pin function: duty 0 is constant low, duty 0xFF constant high
  always_comb begin
    pwm_bit = (pin_src.duty == 8'hFF) || (cnt < pin_src.duty);
    pwm_nxt = pin_src.en_out & (~pin_src.en_pwm | {16{pwm_bit}});
  end

  // Registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_o <= '0;
    end else begin
      pwm_o <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// tb/tb_pwm_update_scheduler.sv - scoreboard bench for pwm_update_scheduler, both PWM_SHADOW_EN builds
module tb_pwm_update_scheduler;

  localparam int DIV    = 4;
  localparam int PERIOD = 256 * DIV;

  typedef struct {
    logic        err;
    logic        has_commit;
    logic [39:0] regs;
  } acc_item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        pending;
  logic        period_start;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] pwm_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k        = 0;
  logic        acc_q    = 1'b0;
  logic        pend_prev = 1'b0;
  acc_item_t   acc_exp[$];
  logic [39:0] commit_exp[$];
  acc_item_t   mit;
  logic [39:0] m_sh;
  logic [39:0] m_com;

  pwm_update_scheduler #(.DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .pending      (pending),
    .period_start (period_start),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .pwm_o        (pwm_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference register map, layout {en_out, en_pwm, duty}
  function automatic logic [39:0] model_write(input logic [39:0] r, input logic [6:0] a,
                                              input logic [7:0] d);
    logic [39:0] n;
    n = r;
    case (a)
      7'h00:   n[31:24] = d;
      7'h01:   n[39:32] = d;
      7'h02:   n[15:8]  = d;
      7'h03:   n[23:16] = d;
      7'h04:   n[7:0]   = d;
      default: ;
    endcase
    return n;
  endfunction

  // Cycle index since reset release; wrap clocks are k % PERIOD == PERIOD-1
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
    acc_q <= wr_valid && wr_ready && !rst;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (acc_q) begin
        check_eq("acc_item_avail", acc_exp.size() > 0, 1);
        if (acc_exp.size() > 0) begin
          mit = acc_exp.pop_front();
          check_eq("wr_err", wr_err, mit.err);
          if (mit.has_commit) check_eq("commit_now", {en_out, en_pwm, duty}, mit.regs);
        end
      end else begin
        check_eq("wr_err_quiet", wr_err, 0);
      end
      if (pend_prev && !pending) begin
        check_eq("commit_avail", commit_exp.size() > 0, 1);
        if (commit_exp.size() > 0) check_eq("commit_regs", {en_out, en_pwm, duty}, commit_exp.pop_front());
        check_eq("period_start_at_commit", period_start, 1);
      end
    end
    pend_prev = pending;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit at_wrap,
                          output int acc_k);
    int        g;
    acc_item_t it;
    g = 0;
    @(negedge clk);
    if (at_wrap) begin
      while ((k % PERIOD) != PERIOD - 1 && g < 2 * PERIOD) begin
        @(negedge clk);
        g++;
      end
      check_eq("wrap_align", k % PERIOD, PERIOD - 1);
    end
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (at_wrap) begin
`ifdef PWM_SHADOW_EN
      check_eq("ready_at_wrap", wr_ready, 0);
`else
      check_eq("ready_at_wrap", wr_ready, 1);
`endif
    end
    g = 0;
    while (!wr_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_eq("accept_wait", wr_ready, 1);
    acc_k = k;
    @(posedge clk);
    it.err = (a > 7'h04);
    m_sh   = model_write(m_sh, a, d);
`ifdef PWM_SHADOW_EN
    it.has_commit = 1'b0;
`else
    m_com         = m_sh;
    it.has_commit = 1'b1;
`endif
    it.regs = m_com;
    acc_exp.push_back(it);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic expect_commit();
`ifdef PWM_SHADOW_EN
    commit_exp.push_back(m_sh);
`endif
    m_com = m_sh;
  endtask

  task automatic wait_period_start();
    int g;
    g = 0;
    @(negedge clk);
    while (!period_start && g < 2 * PERIOD) begin
      @(negedge clk);
      g++;
    end
    check_eq("period_start_seen", period_start, 1);
  endtask

  // Called on the period_start clock; samples one full period of pwm_o[0]
  task automatic measure(output int hi_first, output int hi_second, output logic [14:0] upper);
    hi_first  = 0;
    hi_second = 0;
    for (int j = 0; j < PERIOD; j++) begin
      if (j > 0) @(negedge clk);
      if (j < PERIOD / 2) hi_first += int'(pwm_o[0]);
      else                hi_second += int'(pwm_o[0]);
    end
    upper = pwm_o[15:1];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          hf;
    int          hs;
    logic [14:0] up;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    m_sh     = '0;
    m_com    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", wr_ready, 1);
    check_eq("rst_flags", {wr_err, pending, period_start}, 0);
    check_eq("rst_regs", {en_out, en_pwm, duty}, 0);
    check_eq("rst_pins", pwm_o, 0);
    rst = 1'b0;

    // Mid-period configuration: out[7:0] on, PWM on bit 0, duty 50%
    wait_cycles(100);
    do_write(7'h00, 8'hFF, 1'b0, acc);
    do_write(7'h02, 8'h01, 1'b0, acc);
    do_write(7'h04, 8'h80, 1'b0, acc);
`ifdef PWM_SHADOW_EN
    check_eq("t1_pending", pending, 1);
    check_eq("t1_hold_pins", pwm_o, 0);
    check_eq("t1_hold_regs", {en_out, en_pwm, duty}, m_com);
`endif
    expect_commit();
    wait_period_start();
    measure(hf, hs, up);
    check_eq("t1_high_first", hf, PERIOD / 2);
    check_eq("t1_high_second", hs, 0);
    check_eq("t1_static", up, 15'h007F);

    // Duty extremes in separate periods
    wait_cycles(20);
    do_write(7'h04, 8'h00, 1'b0, acc);
    expect_commit();
    wait_period_start();
    measure(hf, hs, up);
    check_eq("t2_duty0_ones", hf + hs, 0);
    wait_cycles(20);
    do_write(7'h04, 8'hFF, 1'b0, acc);
    expect_commit();
    wait_period_start();
    measure(hf, hs, up);
    check_eq("t2_dutyff_ones", hf + hs, PERIOD);

    // Last write wins within one period
    wait_cycles(20);
    do_write(7'h04, 8'h40, 1'b0, acc);
    do_write(7'h04, 8'hC0, 1'b0, acc);
`ifdef PWM_SHADOW_EN
    check_eq("t3_pending", pending, 1);
`endif
    expect_commit();
    wait_period_start();
    check_eq("t3_pending_after", pending, 0);
    check_eq("t3_duty", duty, 8'hC0);
    measure(hf, hs, up);
    check_eq("t3_high_first", hf, PERIOD / 2);
    check_eq("t3_high_second", hs, PERIOD / 4);

    // Write presented on the wrap clock
    wait_cycles(20);
    do_write(7'h04, 8'h10, 1'b0, acc);
    expect_commit();
    do_write(7'h04, 8'h20, 1'b1, acc);
`ifdef PWM_SHADOW_EN
    check_eq("t4_accept_cycle", acc % PERIOD, 1);
`else
    check_eq("t4_accept_cycle", acc % PERIOD, PERIOD - 1);
`endif
    expect_commit();
    wait_period_start();
    check_eq("t4_duty", duty, 8'h20);

    // Unmapped address
    wait_cycles(20);
    do_write(7'h05, 8'hAA, 1'b0, acc);
    check_eq("t5_pending", pending, 0);
    check_eq("t5_regs", {en_out, en_pwm, duty}, m_com);

    // Reset while a duty change is outstanding
    wait_cycles(20);
    do_write(7'h04, 8'h80, 1'b0, acc);
`ifdef PWM_SHADOW_EN
    check_eq("t6_pending", pending, 1);
    check_eq("t6_duty_held", duty, 8'h20);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", wr_ready, 1);
    check_eq("t6_rst_flags", {wr_err, pending, period_start}, 0);
    check_eq("t6_rst_regs", {en_out, en_pwm, duty}, 0);
    check_eq("t6_rst_pins", pwm_o, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_sh  = '0;
    m_com = '0;
    wait_period_start();
    check_eq("t6_no_commit_regs", {en_out, en_pwm, duty}, 0);
    check_eq("t6_no_commit_pend", pending, 0);
    check_eq("t6_no_commit_pins", pwm_o, 0);

    wait_cycles(5);
    check_eq("acc_q_drained", acc_exp.size(), 0);
    check_eq("commit_q_drained", commit_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
